// File: rtl/io_pkg.sv
// Shared button/command definitions for the front-end input stages.
// Consumers of the press code import the same constants from here.
package io_pkg;

  localparam int NUM_BTN = 5;

  localparam logic [2:0] NXT  = 3'b000;
  localparam logic [2:0] RLS  = 3'b001;
  localparam logic [2:0] CON  = 3'b010;
  localparam logic [2:0] DEL  = 3'b011;
  localparam logic [2:0] RIS  = 3'b100;
  localparam logic [2:0] NONE = 3'b111;

  localparam int BTN_NXT = 0;
  localparam int BTN_RLS = 1;
  localparam int BTN_CON = 2;
  localparam int BTN_DEL = 3;
  localparam int BTN_RIS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Lowest-index high button wins; returns NONE when nothing is high.
  function automatic logic [2:0] prio_code(input logic [NUM_BTN-1:0] lvl);
    logic [2:0] code;
    code = NONE;
    if      (lvl[BTN_NXT]) code = NXT;
    else if (lvl[BTN_RLS]) code = RLS;
    else if (lvl[BTN_CON]) code = CON;
    else if (lvl[BTN_DEL]) code = DEL;
    else if (lvl[BTN_RIS]) code = RIS;
    return code;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button synchroniser and debouncer: r_stable follows the synchronised
// input only after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      // Any agreement restarts the count, so short glitches never accumulate.
      if (r_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_stable <= r_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/button_press_encoder.sv
// Debounces five push-buttons and emits one registered 3-bit command code per
// physical press; a new command requires all buttons released first.
module button_press_encoder
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn,
  output logic [2:0]         press,
  output logic [NUM_BTN-1:0] btn_level
);

  logic [NUM_BTN-1:0] w_level;
  state_t             r_state;
  state_t             w_state_next;
  logic [2:0]         r_press;
  logic [2:0]         w_press_next;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_deb
      btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_deb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_btn    (btn[gi]),
        .o_stable (w_level[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_press <= NONE;
    end else begin
      r_state <= w_state_next;
      r_press <= w_press_next;
    end
  end

  // The code is latched into r_press on the IDLE->FIRE transition, so it is
  // visible exactly while the FSM sits in FIRE.
  always_comb begin
    w_state_next = r_state;
    w_press_next = NONE;
    case (r_state)
      IDLE: begin
        if (|w_level) begin
          w_state_next = FIRE;
          w_press_next = prio_code(w_level);
        end
      end
      FIRE: begin
        w_state_next = HOLD;
      end
      HOLD: begin
        if (w_level == '0) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign press     = r_press;
  assign btn_level = w_level;

endmodule

// File: tb/tb_button_press_encoder.sv
// Scoreboard bench for button_press_encoder with DEBOUNCE_CYCLES=4: stimulus
// queues expected {code, cycle} pairs, a monitor pops them on every press pulse.
module tb_button_press_encoder;
  import io_pkg::*;

  localparam int D   = 4;
  localparam int LAT = D + 3;  // cycle-counter offset from drive time to press pulse

  typedef struct {
    logic [2:0] code;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn = 5'b0;
  logic [2:0] press;
  logic [4:0] btn_level;

  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  button_press_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .press     (press),
    .btn_level (btn_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive buttons and, if a pulse is due, queue its code and cycle.
  task automatic drive(input logic [4:0] v, input bit expect_pulse, input logic [2:0] code);
    exp_t e;
    btn = v;
    if (expect_pulse) begin
      e.code = code;
      e.cyc  = cyc + LAT;
      exp_q.push_back(e);
      $display("stim cyc %0d btn=%b expect code %b at cyc %0d", cyc, v, code, e.cyc);
    end else begin
      $display("stim cyc %0d btn=%b no code expected", cyc, v);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && press !== NONE) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_press at cyc %0d: got %b expected none", cyc, press);
      end else begin
        e = exp_q.pop_front();
        $display("mon  cyc %0d press=%b (expected %b at cyc %0d)", cyc, press, e.code, e.cyc);
        check("press_code", int'(press), int'(e.code));
        check("press_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int t;
    // Reset state
    tick(3);
    check("reset_press", int'(press), int'(NONE));
    check("reset_level", int'(btn_level), 0);
    rst_n = 1'b1;
    tick(3);

    // 1: clean press of btn[2], held 20 cycles
    t = cyc;
    drive(5'b00100, 1'b1, CON);
    tick(5);
    check("s1_level_before", int'(btn_level[2]), 0);
    tick(1);
    check("s1_level_after", int'(btn_level[2]), 1);
    tick(14);
    drive(5'b00000, 1'b0, NONE);
    tick(10);
    check("s1_level_released", int'(btn_level), 0);

    // 2: btn[3] bounces (runs shorter than D), then held
    for (int r = 0; r < 3; r++) begin
      btn = 5'b01000; tick(2);
      btn = 5'b00000; tick(1);
      btn = 5'b01000; tick(3);
      btn = 5'b00000; tick(1);
    end
    check("s2_bounce_level", int'(btn_level), 0);
    drive(5'b01000, 1'b1, DEL);
    tick(12);
    check("s2_level_held", int'(btn_level), 5'b01000);
    drive(5'b00000, 1'b0, NONE);
    tick(10);

    // 3: btn[1] and btn[4] together, then btn[0] while held, then fresh btn[0]
    drive(5'b10010, 1'b1, RLS);
    tick(10);
    drive(5'b10011, 1'b0, NONE);
    tick(12);
    check("s3_level_all", int'(btn_level), 5'b10011);
    drive(5'b00000, 1'b0, NONE);
    tick(10);
    check("s3_level_released", int'(btn_level), 0);

    // 4: fresh btn[0], held for 100 cycles -> single pulse
    drive(5'b00001, 1'b1, NXT);
    tick(100);
    drive(5'b00000, 1'b0, NONE);
    tick(10);

    // 5: 3-cycle glitch on btn[2]
    drive(5'b00100, 1'b0, NONE);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) btn = 5'b00000;
      tick(1);
      check("s5_glitch_level", int'(btn_level), 0);
    end
    tick(5);

    // 6: reset while btn[2] is in HOLD, button held through reset release
    drive(5'b00100, 1'b1, CON);
    tick(12);
    rst_n = 1'b0;
    #1;
    check("s6_rst_press", int'(press), int'(NONE));
    check("s6_rst_level", int'(btn_level), 0);
    tick(3);
    check("s6_rst_press_hold", int'(press), int'(NONE));
    rst_n = 1'b1;
    t = cyc;
    begin
      exp_t e;
      e.code = CON;
      e.cyc  = t + LAT;
      exp_q.push_back(e);
      $display("stim cyc %0d reset released, btn held, expect code %b at cyc %0d", cyc, CON, e.cyc);
    end
    tick(12);
    check("s6_level_held", int'(btn_level), 5'b00100);
    drive(5'b00000, 1'b0, NONE);
    tick(10);

    check("pending_expectations", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
